ps2_kbd_rx: RTL and testbench

// PS/2 keyboard receiver between the raw board pins (usb_fpga_dp = PS/2 clock, usb_fpga_dn = PS/2 data,

---
 rtl/ps2_kbd_rx_if.sv | 11 +
 rtl/ps2_kbd_rx.sv | 167 ++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: scancode stream from the PS/2 receiver to the keyboard matrix logic
interface ps2_kbd_rx_if;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       valid;
    logic       ready;

    modport master (output code, output ext, output brk, output valid, input ready);
    modport slave  (input code, input ext, input brk, input valid, output ready);
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with glitch filter, E0/F0 folding and FWFT scancode FIFO
module ps2_kbd_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 25000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ps2_clk,
    input  logic         ps2_dat,
    ps2_kbd_rx_if.master kbd,
    output logic         err_parity,
    output logic         err_frame,
    output logic         err_timeout,
    output logic         overflow
);
    localparam int FW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall, dat;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          byte_ok;
    logic          ext_p, brk_p;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          is_e0, is_f0, push, pop, full, wr;

    assign dat   = dat_sync[1];
    assign fall  = clk_filt && !clk_sync[1] && filt_cnt == FW'(FILTER_LEN - 1);
    assign is_e0 = shift == 8'hE0;
    assign is_f0 = shift == 8'hF0;
    assign push  = byte_ok && !is_e0 && !is_f0;
    assign pop   = kbd.valid && kbd.ready;
    assign full  = count == (AW+1)'(FIFO_DEPTH);
    assign wr    = push && (!full || pop);

    assign kbd.valid = count != '0;
    assign kbd.code  = kbd.valid ? mem[rp][9:2] : 8'h00;
    assign kbd.ext   = kbd.valid && mem[rp][1];
    assign kbd.brk   = kbd.valid && mem[rp][0];

    // bring both pins into the clock domain; idle level of the pulled-up lines is 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    // filtered clock follows the pin only after FILTER_LEN consecutive opposite samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // frame deserialiser advanced on filtered falls, with in-frame idle timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
            byte_ok     <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            byte_ok     <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: if (!dat) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shift   <= {dat, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (!(^{shift, par_bit})) err_parity <= 1'b1;
                        else if (!dat)            err_frame  <= 1'b1;
                        else                      byte_ok    <= 1'b1;
                    end
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TW'(TIMEOUT)) begin
                    state       <= IDLE;
                    shift       <= '0;
                    bit_cnt     <= '0;
                    tmo_cnt     <= '0;
                    err_timeout <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    // prefix bytes only arm flags; any other good byte consumes them, even if it is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_p <= 1'b0;
            brk_p <= 1'b0;
        end else if (byte_ok) begin
            if (is_e0)      ext_p <= 1'b1;
            else if (is_f0) brk_p <= 1'b1;
            else begin
                ext_p <= 1'b0;
                brk_p <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy; a pop frees the slot a simultaneous push needs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wp       <= wp + AW'(wr);
            rp       <= rp + AW'(pop);
            count    <= count + (AW+1)'(wr) - (AW+1)'(pop);
            overflow <= push && full && !pop;
        end
    end

    // FIFO storage; contents are only visible while count marks them valid
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= {shift, ext_p, brk_p};
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: scoreboard bench driving PS/2 frames into ps2_kbd_rx
module tb_ps2_kbd_rx;
    localparam int FL = 8, TO = 2000, DEPTH = 4, H = 40;

    logic clk = 0, reset_n = 0, ps2_clk = 1, ps2_dat = 1;
    logic err_parity, err_frame, err_timeout, overflow;
    int total = 0, bad = 0, cyc = 0;
    int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0, n_pop = 0, mdl_cnt = 0;
    int stop_cyc = 0, rise_cyc = 0;
    int p0, f0, t0, o0, q0;
    logic prev_v = 0, ext_m = 0, brk_m = 0;
    logic [9:0] sb[$];

    ps2_kbd_rx_if kbd();

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .kbd(kbd),
        .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_byte(logic [7:0] b);
        if (b == 8'hE0) ext_m = 1;
        else if (b == 8'hF0) brk_m = 1;
        else begin
            if (mdl_cnt < DEPTH) begin
                sb.push_back({b, ext_m, brk_m});
                mdl_cnt++;
            end
            ext_m = 0;
            brk_m = 0;
        end
    endtask

    task automatic send(logic [7:0] b, logic par_flip, logic stop, int n);
        logic [10:0] f;
        f = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            tick(H);
            ps2_clk = 0;
            if (i == 10) stop_cyc = cyc;
            tick(H);
            ps2_clk = 1;
        end
        ps2_dat = 1;
        tick(H);
    endtask

    task automatic good(logic [7:0] b);
        expect_byte(b);
        send(b, 1'b0, 1'b1, 11);
        tick(20);
    endtask

    // monitor: count pulses, time valid rise, compare every pop against the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            n_par += int'(err_parity);
            n_frm += int'(err_frame);
            n_to  += int'(err_timeout);
            n_ovf += int'(overflow);
            if (kbd.valid && !prev_v) rise_cyc = cyc;
            if (kbd.valid && kbd.ready) begin
                n_pop++;
                mdl_cnt--;
                check("pop_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) check("pop_entry", {kbd.code, kbd.ext, kbd.brk}, sb.pop_front());
            end
            prev_v = kbd.valid;
        end else prev_v = 0;
    end

    initial begin
        kbd.ready = 0;
        tick(3);
        check("rst_valid", kbd.valid, 0);
        check("rst_head", {kbd.code, kbd.ext, kbd.brk}, 0);
        check("rst_pulses", {err_parity, err_frame, err_timeout, overflow}, 0);
        reset_n = 1;
        tick(5);
        good(8'h1C);
        check("t1_valid", kbd.valid, 1);
        check("t1_latency", rise_cyc - stop_cyc, 2 + FL + 1);
        kbd.ready = 1;
        tick(5);
        check("t1_drained", sb.size(), 0);
        check("t1_valid_low", kbd.valid, 0);
        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        good(8'h75);
        check("t2_drained", sb.size(), 0);
        p0 = n_par; f0 = n_frm; q0 = n_pop;
        send(8'h1C, 1'b1, 1'b1, 11);
        tick(20);
        check("t3_par_cnt", n_par - p0, 1);
        check("t3_par_nofrm", n_frm - f0, 0);
        send(8'h1C, 1'b0, 1'b0, 11);
        tick(20);
        check("t3_frm_cnt", n_frm - f0, 1);
        check("t3_frm_nopar", n_par - p0, 1);
        send(8'h1C, 1'b1, 1'b0, 11);
        tick(20);
        check("t3_both_par", n_par - p0, 2);
        check("t3_both_frm", n_frm - f0, 1);
        check("t3_no_pop", n_pop - q0, 0);
        kbd.ready = 0;
        o0 = n_ovf; q0 = n_pop;
        good(8'h15); good(8'h1D); good(8'h24); good(8'h2D); good(8'h2C);
        check("t4_ovf_cnt", n_ovf - o0, 1);
        check("t4_valid", kbd.valid, 1);
        kbd.ready = 1;
        tick(10);
        check("t4_pops", n_pop - q0, 4);
        check("t4_drained", sb.size(), 0);
        good(8'hF0);
        t0 = n_to;
        send(8'h33, 1'b0, 1'b1, 5);
        tick(TO + 200);
        check("t5_timeout", n_to - t0, 1);
        good(8'h2A);
        check("t5_drained", sb.size(), 0);
        check("t5_timeout_once", n_to - t0, 1);
        p0 = n_par; f0 = n_frm; t0 = n_to; q0 = n_pop;
        ps2_dat = 0;
        repeat (5) begin
            ps2_clk = 0;
            tick(2);
            ps2_clk = 1;
            tick(10);
        end
        ps2_dat = 1;
        tick(20);
        check("t6_glitch_errs", (n_par - p0) + (n_frm - f0) + (n_to - t0), 0);
        check("t6_glitch_valid", kbd.valid, 0);
        good(8'h1C);
        check("t6_drained", sb.size(), 0);
        check("t6_pops", n_pop - q0, 1);
        good(8'hE0);
        send(8'h33, 1'b0, 1'b1, 6);
        reset_n = 0;
        ext_m = 0;
        brk_m = 0;
        tick(3);
        check("t7_rst_valid", kbd.valid, 0);
        reset_n = 1;
        t0 = n_to;
        tick(TO + 100);
        check("t7_valid_after", kbd.valid, 0);
        check("t7_no_timeout", n_to - t0, 0);
        good(8'h1C);
        check("t7_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        bad++;
        $display("FAIL watchdog cycles=%0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
